// File: rtl/ram2_port_master_if.sv
// Client-side bus of ram2_port_master: command, write-data and read-data streams.
// The master modport is the client; the slave modport is the RAM initiator.
interface ram2_port_master_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
) ();
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [ADDRESS_WIDTH-1:0] cmd_len;
  logic                     wdata_valid;
  logic                     wdata_ready;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     rdata_valid;
  logic                     rdata_ready;
  logic [DATA_WIDTH-1:0]    rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
    input  cmd_ready, wdata_ready, rdata_valid, rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
    output cmd_ready, wdata_ready, rdata_valid, rdata
  );
endinterface

// File: rtl/ram2_port_master.sv
// Burst initiator for a single-port synchronous RAM with one-cycle read latency.
// Read data is parked in a 2-entry FIFO; issue is throttled by a credit count.
module ram2_port_master #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ram2_port_master_if.slave        client,
  output logic                     busy,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  function automatic logic [ADDRESS_WIDTH-1:0] next_addr(input logic [ADDRESS_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDRESS_WIDTH'(1'b1);
  endfunction

  state_t                   state_r, state_nxt_s;
  logic [ADDRESS_WIDTH-1:0] cur_addr_r, cur_addr_nxt_s;
  logic [ADDRESS_WIDTH-1:0] remaining_r, remaining_nxt_s;
  logic                     inflight_r;
  logic [DATA_WIDTH-1:0]    fifo_mem_r [2];
  logic                     wr_ptr_r, rd_ptr_r;
  logic [1:0]               fifo_count_r;
  logic                     issue_s, push_s, pop_s, rvalid_s, credit_s;
  logic                     cmd_ready_s, wdata_ready_s, mem_wen_s;
  logic [2:0]               occupancy_s;

  assign rvalid_s    = (fifo_count_r != 2'd0);
  assign pop_s       = rvalid_s && client.rdata_ready;
  assign push_s      = inflight_r;
  // Words held plus the one in flight, less the one leaving this cycle, must stay below 2.
  assign occupancy_s = {1'b0, fifo_count_r} + {2'b00, inflight_r};
  assign credit_s    = ((occupancy_s - {2'b00, pop_s}) < 3'd2);

  // Next-state, address/length bookkeeping and RAM strobes.
  always_comb begin
    state_nxt_s     = state_r;
    cur_addr_nxt_s  = cur_addr_r;
    remaining_nxt_s = remaining_r;
    issue_s         = 1'b0;
    cmd_ready_s     = 1'b0;
    wdata_ready_s   = 1'b0;
    mem_wen_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (client.cmd_valid) begin
          cur_addr_nxt_s  = client.cmd_addr;
          remaining_nxt_s = client.cmd_len;
          state_nxt_s     = client.cmd_write ? ST_WRITE : ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wdata_ready_s = 1'b1;
        mem_wen_s     = client.wdata_valid;
        if (client.wdata_valid) begin
          cur_addr_nxt_s  = next_addr(cur_addr_r);
          remaining_nxt_s = remaining_r - ADDRESS_WIDTH'(1'b1);
          state_nxt_s     = (remaining_r == '0) ? ST_IDLE : ST_WRITE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (credit_s) begin
          issue_s         = 1'b1;
          cur_addr_nxt_s  = next_addr(cur_addr_r);
          remaining_nxt_s = remaining_r - ADDRESS_WIDTH'(1'b1);
          state_nxt_s     = (remaining_r == '0) ? ST_IDLE : ST_READ;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, burst counters and the one-deep read-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cur_addr_r  <= '0;
      remaining_r <= '0;
      inflight_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cur_addr_r  <= cur_addr_nxt_s;
      remaining_r <= remaining_nxt_s;
      inflight_r  <= issue_s;
    end
  end

  // Read FIFO: capture RAM output the cycle after an issue, pop on consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_mem_r[i] <= '0;
      end
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      fifo_count_r <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= mem_dataOut;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + 2'd1;
        2'b01:   fifo_count_r <= fifo_count_r - 2'd1;
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  assign client.cmd_ready   = cmd_ready_s;
  assign client.wdata_ready = wdata_ready_s;
  assign client.rdata_valid = rvalid_s;
  assign client.rdata       = fifo_mem_r[rd_ptr_r];
  assign mem_wEn            = mem_wen_s;
  assign mem_addr           = cur_addr_r;
  assign mem_dataIn         = client.wdata;
  assign busy               = (state_r != ST_IDLE) || inflight_r || rvalid_s;

endmodule

// File: tb/tb_ram2_port_master.sv
// Randomized bench for ram2_port_master: a behavioural RAM, a shadow memory image
// and a queue of expected read words, plus directed burst/latency/reset checks.
module tb_ram2_port_master;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram2_port_master_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) client ();

  logic          busy;
  logic          mem_wEn;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataIn;
  logic [DW-1:0] mem_dataOut;

  ram2_port_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .client      (client),
    .busy        (busy),
    .mem_wEn     (mem_wEn),
    .mem_addr    (mem_addr),
    .mem_dataIn  (mem_dataIn),
    .mem_dataOut (mem_dataOut)
  );

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q   [$];
  int            n_total = 0;
  int            n_bad   = 0;
  int            stall_left = 0;
  bit            rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Single-port synchronous RAM: write on wEn, otherwise register the addressed word.
  always @(posedge clk) begin
    if (mem_wEn) ram[mem_addr] <= mem_dataIn;
    else         mem_dataOut   <= ram[mem_addr];
  end

  // Consumer: ready high, forced low for stall_left cycles, or random.
  initial begin
    client.rdata_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_left > 0) begin
        client.rdata_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        client.rdata_ready = ($urandom_range(0, 3) != 0);
      end else begin
        client.rdata_ready = 1'b1;
      end
    end
  end

  // Every consumed read word must be the next one expected.
  always @(negedge clk) begin
    if (rst_n && client.rdata_valid && client.rdata_ready) begin
      if (exp_q.size() == 0) chk("rd_extra", 32'(exp_q.size()), 32'd1);
      else                   chk("rdata", 32'(client.rdata), 32'(exp_q.pop_front()));
    end
  end

  task automatic send_cmd(input bit wr, input int a, input int l);
    bit acc = 1'b0;
    client.cmd_valid = 1'b1;
    client.cmd_write = wr;
    client.cmd_addr  = AW'(a);
    client.cmd_len   = AW'(l);
    for (int g = 0; g < 100 && !acc; g++) begin
      @(negedge clk);
      acc = client.cmd_ready;
      @(posedge clk);
      #1;
    end
    chk("cmd_accept", 32'(acc), 32'd1);
    client.cmd_valid = 1'b0;
    if (!wr && acc) begin
      for (int i = 0; i <= l; i++) exp_q.push_back(ref_mem[(a + i) % DEPTH]);
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int g = 0; g < 500 && !done; g++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy;
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  // cont: wdata_valid held high; dir: data A0+beat instead of random.
  task automatic write_burst(input int a, input int l, input bit cont, input bit dir);
    int beat = 0;
    int ea;
    send_cmd(1'b1, a, l);
    for (int g = 0; g < 400 && beat <= l; g++) begin
      client.wdata_valid = cont ? 1'b1 : ($urandom_range(0, 2) != 0);
      client.wdata       = dir ? DW'(8'hA0 + beat) : DW'($urandom);
      @(negedge clk);
      if (client.wdata_valid) begin
        ea = (a + beat) % DEPTH;
        chk("wr_ready", 32'(client.wdata_ready), 32'd1);
        chk("wr_wen", 32'(mem_wEn), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'(ea));
        chk("wr_data", 32'(mem_dataIn), 32'(client.wdata));
        ref_mem[ea] = client.wdata;
        beat++;
      end else begin
        chk("wr_idle_wen", 32'(mem_wEn), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    client.wdata_valid = 1'b0;
    @(negedge clk);
    chk("wr_done_cmd_ready", 32'(client.cmd_ready), 32'd1);
    chk("wr_done_wen", 32'(mem_wEn), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high, latency/streaming checks; 1: 5-cycle stall; 2: random ready, no drain.
  task automatic read_burst(input int a, input int l, input int mode);
    if (mode != 2) wait_drain();
    if (mode == 1) stall_left = 5;
    send_cmd(1'b0, a, l);
    if (mode == 0) begin
      for (int n = 1; n <= l + 4; n++) begin
        @(negedge clk);
        if (n == 1) begin
          chk("rd_issue_addr", 32'(mem_addr), 32'(a));
          chk("rd_issue_wen", 32'(mem_wEn), 32'd0);
        end
        chk("rd_valid", 32'(client.rdata_valid), 32'(n >= 3 && n <= l + 3));
        if (n == l + 4) chk("rd_busy_end", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
      end
    end else if (mode == 1) begin
      for (int n = 1; n <= 4; n++) begin
        @(negedge clk);
        if (n == 4) begin
          chk("stall_addr", 32'(mem_addr), 32'((a + 2) % DEPTH));
          chk("stall_valid", 32'(client.rdata_valid), 32'd1);
        end
        @(posedge clk);
        #1;
      end
    end
    if (mode != 2) wait_drain();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(client.cmd_ready), 32'd1);
    chk({tag, "_wdata_ready"}, 32'(client.wdata_ready), 32'd0);
    chk({tag, "_wen"}, 32'(mem_wEn), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_rvalid"}, 32'(client.rdata_valid), 32'd0);
    chk({tag, "_rdata"}, 32'(client.rdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    client.cmd_valid   = 1'b0;
    client.cmd_write   = 1'b0;
    client.cmd_addr    = '0;
    client.cmd_len     = '0;
    client.wdata_valid = 1'b0;
    client.wdata       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill the whole RAM (wrapping from 0x80) so every later read has a known image.
    write_burst(32'h80, 255, 1'b1, 1'b0);

    write_burst(32'h10, 3, 1'b1, 1'b1);
    read_burst(32'h10, 3, 0);
    read_burst(32'h10, 3, 1);

    write_burst(32'hFE, 2, 1'b1, 1'b0);
    read_burst(32'hFE, 2, 0);

    write_burst(32'h40, 0, 1'b1, 1'b0);
    read_burst(32'h40, 0, 0);

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        write_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)), 1'b0, 1'b0);
      end else begin
        rand_ready = 1'b1;
        read_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)), 2);
      end
    end
    rand_ready = 1'b0;
    wait_drain();

    // Abandon a 16-word read after 5 issues; reset must clear everything at once.
    send_cmd(1'b0, 32'h30, 15);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    read_burst(32'h30, 15, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
